// File: rtl/concat_if_pkg.sv
// concat_if_pkg
// Shared types for the concat/if-else byte serializer.
//   state_t      : serializer FSM states
//   result_t     : one buffered upstream result (16-bit concat word + selected byte)
//   WORD_BYTES   : bytes emitted per result
//   result_byte(): byte of a result by index, most significant concat byte first
package concat_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    B2   = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] concat;
    logic [7:0]  if_else;
  } result_t;

  localparam int WORD_BYTES = 3;

  function automatic logic [7:0] result_byte(input result_t r, input logic [1:0] idx);
    case (idx)
      2'd0:    return r.concat[15:8];
      2'd1:    return r.concat[7:0];
      default: return r.if_else;
    endcase
  endfunction

endpackage

// File: rtl/concat_if_fifo.sv
// concat_if_fifo
// Synchronous FIFO of result_t entries.
//   clk, rst       : clock, asynchronous active-high reset
//   i_push, i_data : write request and data (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_head         : entry at the head, valid when !o_empty
//   o_level        : occupancy 0..DEPTH
//   o_full, o_empty: occupancy flags
module concat_if_fifo
  import concat_if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  result_t                  i_data,
  input  logic                     i_pop,
  output result_t                  o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  result_t          r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/concat_if_byte_serializer.sv
// concat_if_byte_serializer
// Buffers 24-bit results in a FIFO and streams each as three bytes
// (concat[15:8], concat[7:0], if_else) with a last-byte marker.
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : upstream handshake; in_ready = FIFO not full
//   in_concat, in_if_else        : result fields
//   out_valid/out_ready          : downstream byte handshake
//   out_byte, out_last           : serialized byte, high on third byte
//   out_level                    : FIFO occupancy
//   out_sent                     : wrapping count of fully delivered results
//
// state | meaning
// IDLE  | nothing on the output; pop head when FIFO non-empty
// B0    | presenting concat[15:8]
// B1    | presenting concat[7:0]
// B2    | presenting if_else with out_last; on accept, chain next result or go idle
module concat_if_byte_serializer
  import concat_if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_concat,
  input  logic [7:0]               in_if_else,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_byte,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   out_level,
  output logic [CNT_W-1:0]         out_sent
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  state_t             r_state;
  result_t            r_hold;
  logic               r_out_valid;
  logic               r_out_last;
  logic [7:0]         r_out_byte;
  logic [CNT_W-1:0]   r_sent;

  result_t            w_head;
  result_t            w_in_data;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_hs;

  assign w_in_data = '{concat: in_concat, if_else: in_if_else};
  assign in_ready  = !w_full;
  assign w_push    = in_valid && in_ready;
  assign w_hs      = r_out_valid && out_ready;

  // Pop either from idle or at the end of a result, so results chain without a bubble.
  assign w_pop = !w_empty && ((r_state == IDLE) || ((r_state == B2) && w_hs));

  concat_if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (out_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_byte  <= 8'h00;
      r_sent      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_hold      <= w_head;
            r_state     <= B0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_out_byte  <= result_byte(w_head, 2'd0);
          end
        end
        B0: begin
          if (w_hs) begin
            r_state    <= B1;
            r_out_byte <= result_byte(r_hold, 2'd1);
          end
        end
        B1: begin
          if (w_hs) begin
            r_state    <= B2;
            r_out_byte <= result_byte(r_hold, LAST_IDX);
            r_out_last <= 1'b1;
          end
        end
        B2: begin
          if (w_hs) begin
            r_sent <= r_sent + 1'b1;
            if (w_pop) begin
              r_hold      <= w_head;
              r_state     <= B0;
              r_out_last  <= 1'b0;
              r_out_byte  <= result_byte(w_head, 2'd0);
            end else begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_byte  <= 8'h00;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_byte  = r_out_byte;
  assign out_sent  = r_sent;

endmodule

// File: tb/tb_concat_if_byte_serializer.sv
module tb_concat_if_byte_serializer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_concat = '0;
  logic [7:0]  in_if_else = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [1:0]  out_level;
  logic [CNT_W-1:0] out_sent;

  int errors = 0;
  int checks = 0;

  concat_if_byte_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_concat  (in_concat),
    .in_if_else (in_if_else),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .out_level  (out_level),
    .out_sent   (out_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of accepted results, the result on the wire and its byte index.
  logic [23:0] m_q[$];
  bit          m_busy = 0;
  int          m_idx = 0;
  logic [23:0] m_cur = '0;
  int          m_sent = 0;

  function automatic logic [7:0] m_byte(input logic [23:0] r, input int idx);
    logic [7:0] b;
    b = (idx == 0) ? r[23:16] : (idx == 1) ? r[15:8] : r[7:0];
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_busy = 0;
      m_idx  = 0;
      m_cur  = '0;
      m_sent = 0;
    end else begin
      bit hs, pop, push;
      hs   = m_busy && out_ready;
      push = in_valid && (m_q.size() < DEPTH);
      pop  = (m_q.size() > 0) && (!m_busy || (hs && m_idx == 2));
      if (hs) begin
        if (m_idx == 2) begin
          m_sent++;
          m_busy = 0;
        end else m_idx++;
      end
      if (pop) begin
        m_cur  = m_q.pop_front();
        m_busy = 1;
        m_idx  = 0;
      end
      if (push) m_q.push_back({in_concat, in_if_else});
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_byte",  32'(out_byte),  32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_out_level", 32'(out_level), 32'd0);
      chk("rst_out_sent",  32'(out_sent),  32'd0);
    end else begin
      chk("out_valid", 32'(out_valid), 32'(m_busy));
      chk("out_byte",  32'(out_byte),  m_busy ? 32'(m_byte(m_cur, m_idx)) : 32'd0);
      chk("out_last",  32'(out_last),  32'(m_busy && m_idx == 2));
      chk("out_level", 32'(out_level), 32'(m_q.size()));
      chk("in_ready",  32'(in_ready),  32'(m_q.size() != DEPTH));
      chk("out_sent",  32'(out_sent),  32'(m_sent % (1 << CNT_W)));
    end
  end

  // Log of accepted bytes {last, byte} with the cycle they were accepted in.
  logic [8:0] log_q[$];
  int         log_cyc[$];
  int         cyc = 0;
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      log_q.push_back({out_last, out_byte});
      log_cyc.push_back(cyc);
    end
    cyc++;
  end

  task automatic push_one(input logic [23:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    {in_concat, in_if_else} = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stuck low, got 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_valid || out_level != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: output still busy, got valid=%0d expected 0", out_valid);
    end
    @(negedge clk);
  endtask

  task automatic chk_log(input string name, input logic [23:0] res[$]);
    chk({name, "_len"}, 32'(log_q.size()), 32'(3 * res.size()));
    for (int i = 0; i < res.size() && 3 * i + 2 < log_q.size(); i++) begin
      for (int k = 0; k < 3; k++)
        chk({name, "_byte"}, 32'(log_q[3*i+k]), 32'({k == 2, m_byte(res[i], k)}));
    end
  endtask

  initial begin
    logic [23:0] exp_q[$];
    logic [23:0] fill_v[4];
    int n;

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single result with latency check
    out_ready = 1'b1;
    log_q.delete();
    in_valid = 1'b1;
    in_concat = 16'hA5C3;
    in_if_else = 8'h7E;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_level_n1", 32'(out_level), 32'd1);
    chk("lat_valid_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_n2", 32'(out_valid), 32'd1);
    chk("lat_byte_n2",  32'(out_byte),  32'hA5);
    wait_idle();
    exp_q = {24'hA5C37E};
    chk_log("single", exp_q);
    chk("single_sent", 32'(out_sent), 32'd1);

    // Backpressure during byte 1
    log_q.delete();
    push_one(24'h11C37E);
    n = 0;
    while (!(out_valid && out_byte == 8'hC3) && n < 20) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_byte",  32'(out_byte),  32'hC3);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    wait_idle();
    exp_q = {24'h11C37E};
    chk_log("bp", exp_q);
    chk("bp_sent", 32'(out_sent), 32'd2);

    // Fill and full: hold register takes one, FIFO takes DEPTH more
    log_q.delete();
    out_ready = 1'b0;
    fill_v = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {in_concat, in_if_else} = fill_v[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_level",    32'(out_level), 32'd2);
    chk("full_in_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    wait_idle();
    exp_q = {fill_v[0], fill_v[1], fill_v[2]};
    chk_log("fill", exp_q);
    chk("fill_sent", 32'(out_sent), 32'd1);

    // Back-to-back: 12 bytes in consecutive cycles
    log_q.delete();
    log_cyc.delete();
    exp_q = {24'hC0FFEE, 24'h123456, 24'hABCDEF, 24'h55AA33};
    for (int i = 0; i < 4; i++) push_one(exp_q[i]);
    wait_idle();
    chk_log("b2b", exp_q);
    for (int i = 1; i < log_cyc.size(); i++)
      chk("b2b_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
    chk("b2b_sent", 32'(out_sent), 32'd1);

    // Reset mid-result after byte 0 is accepted
    push_one(24'hDEAD42);
    n = 0;
    while (!(out_valid && out_byte == 8'hDE) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_level", 32'(out_level), 32'd0);
    chk("midrst_sent",  32'(out_sent),  32'd0);
    chk("midrst_byte",  32'(out_byte),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    push_one(24'h1234AB);
    wait_idle();
    exp_q = {24'h1234AB};
    chk_log("postrst", exp_q);

    // Counter wrap: five results since reset with a 2-bit counter
    for (int i = 0; i < 4; i++) push_one(24'(32'h100 * i + 7));
    wait_idle();
    chk("wrap_sent", 32'(out_sent), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 99) < 60);
      out_ready  = ($urandom_range(0, 99) < 70);
      in_concat  = 16'($urandom);
      in_if_else = 8'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
